// File: rtl/snes_reader.sv
// SNES gamepad poller: latches the pad, shifts in 16 bits, publishes 12 buttons.
// Define SNES_DATA_SYNC_EN to pass snes_data through a two-flop synchronizer.
module snes_reader #(
    parameter int POLL_CYCLES = 416667,
    parameter int HALF_CYCLES = 150
) (
    input  logic        clk_vga,
    input  logic        reset,
    input  logic        snes_data,
    output logic        snes_latch,
    output logic        snes_clk,
    output logic [11:0] buttons,
    output logic        up_out,
    output logic        down_out,
    output logic        left_out,
    output logic        right_out,
    output logic        frame_valid
);

    localparam int PW = $clog2(POLL_CYCLES + 1);
    localparam int HW = $clog2(2 * HALF_CYCLES + 1);
    localparam logic [PW-1:0] P_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HALF_CYCLES - 1);
    localparam logic [HW-1:0] L_LAST = HW'(2 * HALF_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        GAP,
        CLK_LO,
        CLK_HI,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [HW-1:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] shift_q, shift_d;
    logic [11:0] buttons_q, buttons_d;
    logic        latch_q, latch_d;
    logic        sclk_q, sclk_d;
    logic        fv_q, fv_d;
    logic        data_s;
    logic        unused_bits;

`ifdef SNES_DATA_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk_vga or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], snes_data};
        end
    end

    assign data_s = sync_q[1];
`else
    assign data_s = snes_data;
`endif

    always_ff @(posedge clk_vga or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            poll_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= 16'hFFFF;
            buttons_q <= '0;
            latch_q   <= 1'b0;
            sclk_q    <= 1'b1;
            fv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            poll_q    <= poll_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            buttons_q <= buttons_d;
            latch_q   <= latch_d;
            sclk_q    <= sclk_d;
            fv_q      <= fv_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        poll_d    = (poll_q == P_LAST) ? '0 : poll_q + 1'b1;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        shift_d   = shift_q;
        buttons_d = buttons_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (poll_q == '0) state_d = LATCH;
            end
            LATCH: begin
                if (cnt_q == L_LAST) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q == H_LAST) begin
                    cnt_d      = '0;
                    shift_d[0] = data_s;
                    state_d    = CLK_LO;
                end
            end
            CLK_LO: begin
                if (cnt_q == H_LAST) begin
                    cnt_d   = '0;
                    state_d = CLK_HI;
                end
            end
            CLK_HI: begin
                if (cnt_q == H_LAST) begin
                    cnt_d = '0;
                    if (idx_q != 4'd15) begin
                        shift_d[idx_q + 4'd1] = data_s;
                        idx_d   = idx_q + 4'd1;
                        state_d = CLK_LO;
                    end else begin
                        // Publish together with the DONE strobe
                        buttons_d = ~shift_q[11:0];
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
        latch_d = (state_d == LATCH);
        sclk_d  = (state_d != CLK_LO);
        fv_d    = (state_d == DONE);
    end

    assign unused_bits = ^shift_q[15:12];

    assign snes_latch  = latch_q;
    assign snes_clk    = sclk_q;
    assign frame_valid = fv_q;
    assign buttons     = buttons_q;
    assign up_out      = buttons_q[4];
    assign down_out    = buttons_q[5];
    assign left_out    = buttons_q[6];
    assign right_out   = buttons_q[7];

endmodule

// File: tb/tb_snes_reader.sv
// Directed bench for snes_reader with a behavioural SNES pad model.
module tb_snes_reader;

    logic        clk_vga = 1'b0;
    logic        reset;
    logic        snes_data;
    logic        snes_latch;
    logic        snes_clk;
    logic [11:0] buttons;
    logic        up_out;
    logic        down_out;
    logic        left_out;
    logic        right_out;
    logic        frame_valid;

    int checks = 0;
    int errors = 0;

    logic [15:0] press = '0;
    int          pidx = 0;
    logic        ovr_en = 1'b0;
    logic        ovr_val = 1'b1;

    snes_reader #(
        .POLL_CYCLES(100),
        .HALF_CYCLES(2)
    ) dut (
        .clk_vga(clk_vga),
        .reset(reset),
        .snes_data(snes_data),
        .snes_latch(snes_latch),
        .snes_clk(snes_clk),
        .buttons(buttons),
        .up_out(up_out),
        .down_out(down_out),
        .left_out(left_out),
        .right_out(right_out),
        .frame_valid(frame_valid)
    );

    always #5 clk_vga = ~clk_vga;

    // Pad: latch reloads bit 0, each snes_clk rise advances to the next bit
    always @(posedge snes_clk or posedge snes_latch) begin
        if (snes_latch) pidx <= 0;
        else if (pidx < 16) pidx <= pidx + 1;
    end

    always_comb begin
        if (ovr_en) snes_data = ovr_val;
        else if (pidx < 16) snes_data = ~press[pidx[3:0]];
        else snes_data = 1'b1;
    end

    typedef struct {
        string       name;
        logic [15:0] press;
        logic [11:0] exp_btn;
        logic [3:0]  exp_dir;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_vga);
        #1;
    endtask

    task automatic wait_latch(output bit ok);
        int n = 0;
        while (snes_latch && n < 300) begin step(); n++; end
        while (!snes_latch && n < 300) begin step(); n++; end
        ok = (n < 300);
    endtask

    task automatic wait_fv(output bit ok, output logic [11:0] pre);
        int n = 0;
        pre = buttons;
        ok = 1'b0;
        while (n < 300) begin
            step();
            n++;
            if (frame_valid) begin
                ok = 1'b1;
                break;
            end
            pre = buttons;
        end
    endtask

    initial begin
        bit          ok;
        logic [11:0] pre;
        logic [11:0] prev_exp;
        int lat_first, lat_last, lo_pulses, lo_cycles, fv_cyc, fv_cnt;
        logic prev_clk, prev_lat;
        int n;

        vecs[0] = '{"up",         16'h0010, 12'h010, 4'b0001};
        vecs[1] = '{"right_a",    16'h0180, 12'h180, 4'b1000};
        vecs[2] = '{"release",    16'h0000, 12'h000, 4'b0000};
        vecs[3] = '{"up_down",    16'h0030, 12'h030, 4'b0011};
        vecs[4] = '{"left_start", 16'h0048, 12'h048, 4'b0100};
        vecs[5] = '{"hi_ignored", 16'hF000, 12'h000, 4'b0000};
        vecs[6] = '{"all",        16'h0FFF, 12'hFFF, 4'b1111};

        reset = 1'b0;
        repeat (3) step();
        chk("rst_latch", snes_latch, 1'b0);
        chk("rst_clk", snes_clk, 1'b1);
        chk("rst_buttons", buttons, 12'h000);
        chk("rst_fv", frame_valid, 1'b0);

        @(negedge clk_vga);
        reset = 1'b1;
        lat_first = 0; lat_last = 0; lo_pulses = 0;
        lo_cycles = 0; fv_cyc = 0; fv_cnt = 0;
        prev_clk = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            step();
            if (snes_latch) begin
                if (lat_first == 0) lat_first = c;
                lat_last = c;
            end
            if (!snes_clk) lo_cycles++;
            if (prev_clk && !snes_clk) lo_pulses++;
            prev_clk = snes_clk;
            if (frame_valid) begin
                fv_cnt++;
                if (fv_cyc == 0) fv_cyc = c;
            end
        end
        chk("latch_first", lat_first, 1);
        chk("latch_last", lat_last, 4);
        chk("lo_pulses", lo_pulses, 16);
        chk("lo_cycles", lo_cycles, 32);
        chk("fv_cycle", fv_cyc, 71);
        chk("fv_count", fv_cnt, 1);
        chk("idle_buttons", buttons, 12'h000);
        chk("idle_dirs", {right_out, left_out, down_out, up_out}, 4'b0000);

        wait_latch(ok);
        chk("spacing_start", ok, 1'b1);
        n = 0; fv_cnt = 0; prev_lat = 1'b1;
        while (n < 300) begin
            step();
            n++;
            if (frame_valid) fv_cnt++;
            if (snes_latch && !prev_lat) break;
            prev_lat = snes_latch;
        end
        chk("latch_spacing", n, 100);
        chk("fv_per_period", fv_cnt, 1);

        prev_exp = 12'h000;
        for (int i = 0; i < 7; i++) begin
            wait_fv(ok, pre);
            press = vecs[i].press;
            wait_fv(ok, pre);
            chk({vecs[i].name, "_timeout"}, ok, 1'b1);
            chk({vecs[i].name, "_hold"}, pre, prev_exp);
            chk({vecs[i].name, "_btn"}, buttons, vecs[i].exp_btn);
            chk({vecs[i].name, "_dir"},
                {right_out, left_out, down_out, up_out}, vecs[i].exp_dir);
            prev_exp = vecs[i].exp_btn;
        end

        press = 16'h0010;
        wait_latch(ok);
        chk("mid_latch", ok, 1'b1);
        repeat (34) step();
        chk("pre_reset_lo", snes_clk, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("async_latch", snes_latch, 1'b0);
        chk("async_clk", snes_clk, 1'b1);
        chk("async_buttons", buttons, 12'h000);
        chk("async_up", up_out, 1'b0);
        chk("async_fv", frame_valid, 1'b0);
        @(negedge clk_vga);
        reset = 1'b1;
        step();
        chk("restart_latch", snes_latch, 1'b1);
        wait_fv(ok, pre);
        chk("restart_timeout", ok, 1'b1);
        chk("restart_pre", pre, 12'h000);
        chk("restart_btn", buttons, 12'h010);
        chk("restart_up", up_out, 1'b1);

`ifdef SNES_DATA_SYNC_EN
        press = 16'h0000;
        ovr_en = 1'b1;
        ovr_val = 1'b1;
        wait_latch(ok);
        repeat (5) step();
        ovr_val = 1'b0;
        repeat (2) step();
        ovr_val = 1'b1;
        wait_fv(ok, pre);
        chk("sync_late_btn", buttons, 12'h000);
        wait_latch(ok);
        repeat (3) step();
        ovr_val = 1'b0;
        repeat (4) step();
        ovr_val = 1'b1;
        wait_fv(ok, pre);
        chk("sync_early_btn", buttons, 12'h001);
        ovr_en = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
